// File: rtl/tinyalu_arbiter_if.sv
// tinyalu_arbiter_if: requester command/response bus plus TinyALU pin bundle.
// Latency: none; this is wiring only.
// Backpressure: req_ready gates commands; responses and ALU pins carry none.
//
// Signals:
//   req_valid/req_ready  per-requester command handshake (ready is one-hot)
//   req_a/req_b/req_op   packed operands (8 bits each) and opcodes (3 bits each)
//   rsp_valid            one-hot, one-cycle response strobe
//   rsp_result/rsp_error result and error flag for the strobed requester
//   alu_*                TinyALU pins: a, b, op, start out; done, result in
// Modports: slave = arbiter side, master = requesters + ALU side.
interface tinyalu_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [3*NUM_REQ-1:0] req_op;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [15:0]          rsp_result;
   logic                 rsp_error;
   logic [7:0]           alu_a;
   logic [7:0]           alu_b;
   logic [2:0]           alu_op;
   logic                 alu_start;
   logic                 alu_done;
   logic [15:0]          alu_result;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_done, alu_result,
      output req_ready, rsp_valid, rsp_result, rsp_error,
             alu_a, alu_b, alu_op, alu_start
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_done, alu_result,
      input  req_ready, rsp_valid, rsp_result, rsp_error,
             alu_a, alu_b, alu_op, alu_start
   );
endinterface

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin sharing of one TinyALU among NUM_REQ requesters.
// Latency: ALU ops respond on the edge alu_done is sampled; no_op/illegal respond one cycle after accept.
// Backpressure: req_ready only in IDLE; responses are never stalled.
//
// Ports:
//   clk      core clock, all logic on posedge
//   reset_n  asynchronous active-low reset; drops every output to 0 at once
//   bus      tinyalu_arbiter_if.slave (requester handshake, responses, ALU pins)
//   busy     high whenever the FSM is not in IDLE
module tinyalu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   tinyalu_arbiter_if.slave bus,
   output logic             busy
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        owner_q, owner_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [7:0]           alu_a_q, alu_a_d;
   logic [7:0]           alu_b_q, alu_b_d;
   logic [2:0]           alu_op_q, alu_op_d;
   logic                 alu_start_q, alu_start_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [15:0]          rsp_result_q, rsp_result_d;
   logic                 rsp_error_q, rsp_error_d;

   logic                 win_found;
   logic [PW-1:0]        win_idx;
   logic [7:0]           win_a;
   logic [7:0]           win_b;
   logic [2:0]           win_op;
   logic [NUM_REQ-1:0]   grant;

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
   // (NUM_REQ need not be a power of two, hence the explicit modulo).
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!win_found && bus.req_valid[PW'(idx)]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
   end

   // Operand mux for the winner.
   always_comb begin
      win_a = '0;
      win_b = '0;
      win_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == win_idx) begin
            win_a  = bus.req_a[8*i +: 8];
            win_b  = bus.req_b[8*i +: 8];
            win_op = bus.req_op[3*i +: 3];
         end
      end
   end

   // Ready is gated by reset_n so it reads 0 while reset is held even
   // though the FSM already sits in IDLE.
   always_comb begin
      grant = '0;
      if (reset_n && state_q == IDLE && win_found) begin
         grant[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      alu_start_d  = alu_start_q;
      rsp_valid_d  = '0;
      rsp_result_d = '0;
      rsp_error_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               owner_d = win_idx;
               cnt_d   = '0;
               case (win_op)
                  3'b001, 3'b010, 3'b011, 3'b100: begin
                     state_d     = ISSUE;
                     alu_start_d = 1'b1;
                     alu_a_d     = win_a;
                     alu_b_d     = win_b;
                     alu_op_d    = win_op;
                  end
                  default: begin
                     // no_op answers cleanly; 101..111 answer with error.
                     state_d              = RESP;
                     rsp_valid_d[win_idx] = 1'b1;
                     rsp_error_d          = (win_op != 3'b000);
                  end
               endcase
            end
         end

         ISSUE: begin
            // done is checked first so a done on the last watchdog cycle wins.
            if (bus.alu_done) begin
               state_d              = RESP;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_result_d         = bus.alu_result;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d              = RESP;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_error_d          = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (state_d == RESP) begin
               alu_start_d = 1'b0;
               alu_a_d     = '0;
               alu_b_d     = '0;
               alu_op_d    = '0;
            end
         end

         RESP: begin
            state_d = IDLE;
            ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         alu_start_q  <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         alu_start_q  <= alu_start_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
      end
   end

   assign bus.req_ready  = grant;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_error  = rsp_error_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.alu_start  = alu_start_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed bench for the TinyALU round-robin arbiter.
// Latency: inputs driven 1 time unit after posedge, outputs sampled after posedge or at negedge.
// Backpressure: requesters hold valid until granted; a behavioural ALU answers start/done.
module tb_tinyalu_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic busy;

   int errors = 0;
   int checks = 0;

   tinyalu_arbiter_if #(.NUM_REQ(4)) bus ();

   tinyalu_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: raises done alu_lat cycles after start is seen high.
   bit  alu_en   = 1'b0;
   bit  alu_hang = 1'b0;
   int  alu_lat  = 1;
   int  alu_cnt  = 0;

   function automatic logic [15:0] alu_calc(logic [7:0] a, logic [7:0] b, logic [2:0] op);
      case (op)
         3'b001:  return 16'(a) + 16'(b);
         3'b010:  return {8'h00, a & b};
         3'b011:  return {8'h00, a ^ b};
         3'b100:  return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   always begin
      @(posedge clk);
      #2;
      if (alu_en) begin
         if (reset_n && bus.alu_start) begin
            if (!alu_hang) begin
               alu_cnt++;
               if (alu_cnt >= alu_lat) begin
                  bus.alu_done   = 1'b1;
                  bus.alu_result = alu_calc(bus.alu_a, bus.alu_b, bus.alu_op);
               end
            end
         end else begin
            bus.alu_done   = 1'b0;
            bus.alu_result = '0;
            alu_cnt        = 0;
         end
      end
   end

   // Monitor: grants, responses and start-low gaps, sampled at negedge.
   int          grant_q[$];
   logic [3:0]  rv_q[$];
   logic [15:0] rr_q[$];
   logic        re_q[$];
   int          start_rises = 0;
   int          min_gap     = 1000;
   int          lo_run      = 0;
   bit          seen_start  = 1'b0;
   logic        start_prev  = 1'b0;

   always @(negedge clk) begin
      logic [3:0] g;
      g = bus.req_valid & bus.req_ready;
      for (int i = 0; i < 4; i++) if (g[i]) grant_q.push_back(i);
      if (bus.rsp_valid != 4'b0000) begin
         rv_q.push_back(bus.rsp_valid);
         rr_q.push_back(bus.rsp_result);
         re_q.push_back(bus.rsp_error);
      end
      if (bus.alu_start) begin
         if (!start_prev) begin
            start_rises++;
            if (seen_start && lo_run < min_gap) min_gap = lo_run;
            seen_start = 1'b1;
         end
         lo_run = 0;
      end else begin
         lo_run++;
      end
      start_prev = bus.alu_start;
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task clear_mon;
      grant_q.delete();
      rv_q.delete();
      rr_q.delete();
      re_q.delete();
      start_rises = 0;
      min_gap     = 1000;
      seen_start  = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bus.req_a[8*i +: 8]  = a;
      bus.req_b[8*i +: 8]  = b;
      bus.req_op[3*i +: 3] = op;
   endtask

   // Runs one command already presented on req_valid; returns start-high cycles and the response.
   task automatic run_cmd(output int hi, output bit got, output logic [3:0] rv,
                          output logic [15:0] rr, output logic re);
      hi = 0; got = 1'b0; rv = '0; rr = '0; re = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         tick;
         bus.req_valid = '0;
         if (bus.alu_start) hi++;
         if (bus.rsp_valid != 4'b0000) begin
            got = 1'b1;
            rv  = bus.rsp_valid;
            rr  = bus.rsp_result;
            re  = bus.rsp_error;
         end
      end
      tick;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rsp_timeout: no response within 40 cycles, got=%0b required 1", got);
      end
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 40 && busy; c++) tick;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b required 0", name, busy);
      end
   endtask

   task test_reset;
      alu_en         = 1'b0;
      reset_n        = 1'b0;
      bus.req_valid  = 4'($urandom_range(1, 15));
      bus.req_a      = $urandom;
      bus.req_b      = $urandom;
      bus.req_op     = 12'($urandom);
      bus.alu_done   = 1'b1;
      bus.alu_result = 16'($urandom);
      repeat (3) tick;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready: got %b required 0000", bus.req_ready);
      end
      checks++;
      if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b} !== 20'h0) begin
         errors++; $display("FAIL reset_alu: start=%b op=%b a=%h b=%h required all 0",
                             bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error} !== 21'h0) begin
         errors++; $display("FAIL reset_rsp: valid=%b result=%h error=%b required all 0",
                             bus.rsp_valid, bus.rsp_result, bus.rsp_error);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b required 0", busy);
      end
      bus.req_valid  = '0;
      bus.alu_done   = 1'b0;
      bus.alu_result = '0;
      reset_n        = 1'b1;
      alu_en         = 1'b1;
      repeat (3) tick;
      checks++;
      if ({busy, bus.alu_start, bus.rsp_valid, bus.req_ready} !== 10'h0) begin
         errors++; $display("FAIL post_reset_idle: busy=%b start=%b rsp_valid=%b ready=%b required all 0",
                             busy, bus.alu_start, bus.rsp_valid, bus.req_ready);
      end
   endtask

   task test_fairness;
      int          exp_g[5];
      logic [3:0]  exp_v[5];
      logic [15:0] exp_r[5];
      exp_g = '{0, 1, 2, 3, 0};
      exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_r = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3};
      clear_mon();
      alu_hang = 1'b0;
      alu_lat  = 3;
      for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd3, 3'b100);
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 200 && grant_q.size() < 5; c++) tick;
      bus.req_valid = '0;
      wait_idle("fair");
      checks++;
      if (grant_q.size() != 5 || rv_q.size() != 5) begin
         errors++; $display("FAIL fair_count: grants=%0d responses=%0d required 5 and 5",
                             grant_q.size(), rv_q.size());
      end
      for (int k = 0; k < 5 && k < grant_q.size() && k < rv_q.size(); k++) begin
         checks++;
         if (grant_q[k] != exp_g[k] || rv_q[k] !== exp_v[k] || rr_q[k] !== exp_r[k] || re_q[k] !== 1'b0) begin
            errors++; $display("FAIL fair_%0d: grant=%0d rsp_valid=%b result=%0d error=%b required %0d %b %0d 0",
                                k, grant_q[k], rv_q[k], rr_q[k], re_q[k], exp_g[k], exp_v[k], exp_r[k]);
         end
      end
      checks++;
      if (min_gap != 2) begin
         errors++; $display("FAIL fair_gap: min start-low gap=%0d required 2", min_gap);
      end
   endtask

   task test_add;
      clear_mon();
      alu_lat = 1;
      set_req(0, 8'h12, 8'h34, 3'b001);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++; $display("FAIL add_ready: got %b required 0001", bus.req_ready);
      end
      tick;
      bus.req_valid = '0;
      checks++;
      if ({busy, bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, 1'b1, 3'b001, 8'h12, 8'h34}) begin
         errors++; $display("FAIL add_issue: busy=%b start=%b op=%b a=%h b=%h required 1 1 001 12 34",
                             busy, bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      tick;
      checks++;
      if ({bus.alu_start, bus.alu_op, bus.rsp_valid, bus.rsp_result, bus.rsp_error} !==
          {1'b0, 3'b000, 4'b0001, 16'h0046, 1'b0}) begin
         errors++; $display("FAIL add_rsp: start=%b op=%b valid=%b result=%h error=%b required 0 000 0001 0046 0",
                             bus.alu_start, bus.alu_op, bus.rsp_valid, bus.rsp_result, bus.rsp_error);
      end
      tick;
      checks++;
      if (bus.rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL add_strobe_len: rsp_valid=%b required 0000", bus.rsp_valid);
      end
      wait_idle("add");
   endtask

   task test_local_ops;
      clear_mon();
      set_req(2, 8'h55, 8'h66, 3'b000);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         errors++; $display("FAIL noop_ready: got %b required 0100", bus.req_ready);
      end
      tick;
      bus.req_valid = '0;
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.alu_start} !== {4'b0100, 16'h0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL noop_rsp: valid=%b result=%h error=%b start=%b required 0100 0000 0 0",
                             bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.alu_start);
      end
      tick;
      checks++;
      if ({busy, bus.rsp_valid} !== 5'b0) begin
         errors++; $display("FAIL noop_done: busy=%b rsp_valid=%b required 0 0000", busy, bus.rsp_valid);
      end
      set_req(2, 8'h55, 8'h66, 3'b110);
      bus.req_valid = 4'b0100;
      tick;
      bus.req_valid = '0;
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error} !== {4'b0100, 16'h0, 1'b1}) begin
         errors++; $display("FAIL illegal_rsp: valid=%b result=%h error=%b required 0100 0000 1",
                             bus.rsp_valid, bus.rsp_result, bus.rsp_error);
      end
      tick;
      checks++;
      if (start_rises != 0) begin
         errors++; $display("FAIL local_no_start: start rises=%0d required 0", start_rises);
      end
   endtask

   task test_watchdog;
      int hi; bit got; logic [3:0] rv; logic [15:0] rr; logic re;
      alu_hang = 1'b1;
      set_req(1, 8'd7, 8'd8, 3'b001);
      bus.req_valid = 4'b0010;
      run_cmd(hi, got, rv, rr, re);
      checks++;
      if (hi != 16 || {rv, rr, re} !== {4'b0010, 16'h0, 1'b1}) begin
         errors++; $display("FAIL watchdog: start_cycles=%0d valid=%b result=%h error=%b required 16 0010 0000 1",
                             hi, rv, rr, re);
      end
      alu_hang = 1'b0;
      alu_lat  = 2;
      set_req(3, 8'd9, 8'd4, 3'b011);
      bus.req_valid = 4'b1000;
      run_cmd(hi, got, rv, rr, re);
      checks++;
      if (hi != 2 || {rv, rr, re} !== {4'b1000, 16'h000D, 1'b0}) begin
         errors++; $display("FAIL after_watchdog: start_cycles=%0d valid=%b result=%h error=%b required 2 1000 000d 0",
                             hi, rv, rr, re);
      end
   endtask

   task test_done_at_timeout;
      int hi; bit got; logic [3:0] rv; logic [15:0] rr; logic re;
      alu_lat = 16;
      set_req(0, 8'd200, 8'd100, 3'b001);
      bus.req_valid = 4'b0001;
      run_cmd(hi, got, rv, rr, re);
      checks++;
      if (hi != 16 || {rv, rr, re} !== {4'b0001, 16'h012C, 1'b0}) begin
         errors++; $display("FAIL done_at_timeout: start_cycles=%0d valid=%b result=%h error=%b required 16 0001 012c 0",
                             hi, rv, rr, re);
      end
   endtask

   task test_reset_mid_issue;
      int hi; bit got; logic [3:0] rv; logic [15:0] rr; logic re;
      // A no_op from requester 2 moves the pointer to 3, so a pointer that
      // survived reset would grant requester 3 rather than 1.
      set_req(2, 8'h00, 8'h00, 3'b000);
      bus.req_valid = 4'b0100;
      run_cmd(hi, got, rv, rr, re);
      alu_lat = 10;
      set_req(2, 8'd1, 8'd1, 3'b001);
      bus.req_valid = 4'b0100;
      tick;
      bus.req_valid = '0;
      checks++;
      if (bus.alu_start !== 1'b1) begin
         errors++; $display("FAIL mid_issue_start: got %b required 1", bus.alu_start);
      end
      tick;
      tick;
      clear_mon();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.alu_start, busy, bus.alu_op} !== 5'b0) begin
         errors++; $display("FAIL async_reset: start=%b busy=%b op=%b required 0 0 000",
                             bus.alu_start, busy, bus.alu_op);
      end
      set_req(1, 8'd1, 8'd2, 3'b001);
      set_req(3, 8'd5, 8'd5, 3'b001);
      bus.req_valid = 4'b1010;
      repeat (2) tick;
      checks++;
      if (bus.req_ready !== 4'b0000 || rv_q.size() != 0) begin
         errors++; $display("FAIL reset_hold: ready=%b responses=%0d required 0000 0",
                             bus.req_ready, rv_q.size());
      end
      reset_n = 1'b1;
      alu_lat = 1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++; $display("FAIL restart_grant: ready=%b required 0010", bus.req_ready);
      end
      run_cmd(hi, got, rv, rr, re);
      checks++;
      if ({rv, rr, re} !== {4'b0010, 16'h0003, 1'b0}) begin
         errors++; $display("FAIL restart_rsp: valid=%b result=%h error=%b required 0010 0003 0", rv, rr, re);
      end
      wait_idle("restart");
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_op     = '0;
      bus.alu_done   = 1'b0;
      bus.alu_result = '0;
      tick;
      test_reset();
      test_fairness();
      test_add();
      test_local_ops();
      test_watchdog();
      test_done_at_timeout();
      test_reset_mid_issue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
